// File: rtl/mc_ctrl_gen.sv
// Multicycle MIPS control unit with handshaked instruction/data memory, a bounded
// wait timeout and configurable overflow handling (ignore, flag in $30, or trap).
module mc_ctrl_gen #(
  parameter int unsigned TIMEOUT  = 16,  // max wait cycles per handshake, 0 = never
  parameter int unsigned OVF_MODE = 1,   // 0 ignore, 1 write 1 to $30, 2 trap
  parameter int unsigned ILL_TRAP = 1    // 1 = unsupported instruction traps
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       overflow,
  input  logic       imem_ready,
  input  logic       dmem_ready,
  output logic       imem_req,
  output logic       dmem_req,
  output logic       pc_write,
  output logic       ir_write,
  output logic       reg_write,
  output logic       mem_write,
  output logic       epc_write,
  output logic       alu_src,
  output logic       lb_sign,
  output logic       sb_sign,
  output logic [1:0] reg_dst,
  output logic [2:0] mem_to_reg,
  output logic [2:0] npc_op,
  output logic [1:0] ext_op,
  output logic [2:0] alu_op,
  output logic [1:0] cause,
  output logic [3:0] state_o
);

  typedef enum logic [3:0] {
    StIf     = 4'd0,
    StId     = 4'd1,
    StExeLs  = 4'd2,
    StMemSt  = 4'd3,
    StMemLd  = 4'd4,
    StWbDm   = 4'd5,
    StExeBr  = 4'd6,
    StExeCal = 4'd7,
    StWbCal  = 4'd8,
    StWbJal  = 4'd9,
    StExeJr  = 4'd10,
    StBranch = 4'd11,
    StTrap   = 4'd12
  } state_e;

  localparam logic [5:0] OpRtype = 6'h00;
  localparam logic [5:0] OpJ     = 6'h02;
  localparam logic [5:0] OpJal   = 6'h03;
  localparam logic [5:0] OpBeq   = 6'h04;
  localparam logic [5:0] OpBne   = 6'h05;
  localparam logic [5:0] OpAddi  = 6'h08;
  localparam logic [5:0] OpAddiu = 6'h09;
  localparam logic [5:0] OpOri   = 6'h0D;
  localparam logic [5:0] OpLui   = 6'h0F;
  localparam logic [5:0] OpLb    = 6'h20;
  localparam logic [5:0] OpLw    = 6'h23;
  localparam logic [5:0] OpSb    = 6'h28;
  localparam logic [5:0] OpSw    = 6'h2B;

  localparam logic [5:0] FnJr   = 6'h08;
  localparam logic [5:0] FnAddu = 6'h21;
  localparam logic [5:0] FnSubu = 6'h23;
  localparam logic [5:0] FnSlt  = 6'h2A;

  localparam logic [1:0] CauseOvf = 2'b01;
  localparam logic [1:0] CauseIll = 2'b10;
  localparam logic [1:0] CauseBus = 2'b11;

  localparam int unsigned CntW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              ovf_q, ovf_d;
  logic [1:0]        cause_q, cause_d;

  logic is_r, is_addu, is_subu, is_slt, is_jr;
  logic is_j, is_jal, is_beq, is_bne, is_addi, is_addiu, is_ori, is_lui;
  logic is_lw, is_lb, is_sw, is_sb;
  logic is_load, is_store, is_br, is_cal;
  logic wait_state, ready_cur, timeout_hit;

  // Instruction class decode from the current IR fields
  always_comb begin
    is_r     = (opcode == OpRtype);
    is_addu  = is_r && (funct == FnAddu);
    is_subu  = is_r && (funct == FnSubu);
    is_slt   = is_r && (funct == FnSlt);
    is_jr    = is_r && (funct == FnJr);
    is_j     = (opcode == OpJ);
    is_jal   = (opcode == OpJal);
    is_beq   = (opcode == OpBeq);
    is_bne   = (opcode == OpBne);
    is_addi  = (opcode == OpAddi);
    is_addiu = (opcode == OpAddiu);
    is_ori   = (opcode == OpOri);
    is_lui   = (opcode == OpLui);
    is_lw    = (opcode == OpLw);
    is_lb    = (opcode == OpLb);
    is_sw    = (opcode == OpSw);
    is_sb    = (opcode == OpSb);
    is_load  = is_lw || is_lb;
    is_store = is_sw || is_sb;
    is_br    = is_beq || is_bne;
    is_cal   = is_addu || is_subu || is_slt || is_ori || is_lui || is_addi || is_addiu;
  end

  // Datapath selects are pure opcode/funct decodes, independent of state
  always_comb begin
    alu_src = is_ori || is_lui || is_addi || is_addiu || is_load || is_store;
    lb_sign = is_lb;
    sb_sign = is_sb;
    ext_op  = 2'b00;
    if (is_lui) begin
      ext_op = 2'b10;
    end else if (is_addi || is_addiu || is_load || is_store || is_br) begin
      ext_op = 2'b01;
    end
    alu_op = 3'b000;
    if (is_subu || is_br) begin
      alu_op = 3'b001;
    end else if (is_ori) begin
      alu_op = 3'b010;
    end else if (is_slt) begin
      alu_op = 3'b011;
    end else if (is_addi) begin
      alu_op = 3'b100;
    end else if (is_lui) begin
      alu_op = 3'b101;
    end
  end

  // Handshake wait tracking; the trap fires in the cycle the count would reach TIMEOUT
  always_comb begin
    wait_state  = (state_q == StIf) || (state_q == StMemSt) || (state_q == StMemLd);
    ready_cur   = (state_q == StIf) ? imem_ready : dmem_ready;
    timeout_hit = (TIMEOUT != 0) && wait_state && !ready_cur &&
                  ((32'(cnt_q) + 32'd1) >= TIMEOUT);
  end

  // Next-state, overflow flag and trap cause
  always_comb begin
    state_d = state_q;
    ovf_d   = ovf_q;
    cause_d = cause_q;
    case (state_q)
      StIf: begin
        if (imem_ready) begin
          state_d = StId;
        end else if (timeout_hit) begin
          state_d = StTrap;
          cause_d = CauseBus;
        end
      end
      StId: begin
        if (is_j) begin
          state_d = StBranch;
        end else if (is_jal) begin
          state_d = StWbJal;
        end else if (is_jr) begin
          state_d = StExeJr;
        end else if (is_load || is_store) begin
          state_d = StExeLs;
        end else if (is_br) begin
          state_d = StExeBr;
        end else if (is_cal) begin
          state_d = StExeCal;
        end else if (ILL_TRAP != 0) begin
          state_d = StTrap;
          cause_d = CauseIll;
        end else begin
          state_d = StIf;
        end
      end
      StExeLs: state_d = is_load ? StMemLd : StMemSt;
      StMemSt: begin
        if (dmem_ready) begin
          state_d = StIf;
        end else if (timeout_hit) begin
          state_d = StTrap;
          cause_d = CauseBus;
        end
      end
      StMemLd: begin
        if (dmem_ready) begin
          state_d = StWbDm;
        end else if (timeout_hit) begin
          state_d = StTrap;
          cause_d = CauseBus;
        end
      end
      StExeCal: begin
        // The flag being latched decides the exit so a trapped addi never writes back
        ovf_d = overflow && is_addi;
        if ((OVF_MODE == 2) && ovf_d) begin
          state_d = StTrap;
          cause_d = CauseOvf;
        end else begin
          state_d = StWbCal;
        end
      end
      StExeBr, StWbJal, StExeJr: state_d = StBranch;
      StWbDm, StWbCal, StBranch, StTrap: state_d = StIf;
      default: state_d = StIf;
    endcase
  end

  // Wait counter restarts on every state change and counts cycles without ready
  always_comb begin
    cnt_d = cnt_q;
    if (state_d != state_q) begin
      cnt_d = '0;
    end else if (wait_state && !ready_cur) begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  // State registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIf;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      cause_q <= 2'b00;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      cause_q <= cause_d;
    end
  end

  // Moore outputs from state; enables and requests are forced low during reset
  always_comb begin
    imem_req   = 1'b0;
    dmem_req   = 1'b0;
    pc_write   = 1'b0;
    ir_write   = 1'b0;
    reg_write  = 1'b0;
    mem_write  = 1'b0;
    epc_write  = 1'b0;
    reg_dst    = 2'b00;
    mem_to_reg = 3'b000;
    npc_op     = 3'b000;
    case (state_q)
      StIf: begin
        imem_req = !timeout_hit;
        ir_write = imem_ready;
        pc_write = imem_ready;
      end
      StMemSt: begin
        dmem_req  = !timeout_hit;
        mem_write = !timeout_hit;
      end
      StMemLd: dmem_req = !timeout_hit;
      StWbDm: begin
        reg_write  = 1'b1;
        mem_to_reg = 3'b001;
      end
      StWbCal: begin
        reg_write = 1'b1;
        reg_dst   = is_r ? 2'b01 : 2'b00;
        if ((OVF_MODE == 1) && ovf_q) begin
          reg_dst    = 2'b11;
          mem_to_reg = 3'b011;
        end
      end
      StWbJal: begin
        reg_write  = 1'b1;
        reg_dst    = 2'b10;
        mem_to_reg = 3'b010;
      end
      StBranch: begin
        pc_write = is_j || is_jal || is_jr || (is_beq && zero) || (is_bne && !zero);
        if (is_br) begin
          npc_op = 3'b001;
        end else if (is_jr) begin
          npc_op = 3'b011;
        end else begin
          npc_op = 3'b010;
        end
      end
      StTrap: begin
        epc_write = 1'b1;
        pc_write  = 1'b1;
        npc_op    = 3'b100;
      end
      default: ;
    endcase
    if (reset) begin
      imem_req  = 1'b0;
      dmem_req  = 1'b0;
      pc_write  = 1'b0;
      ir_write  = 1'b0;
      reg_write = 1'b0;
      mem_write = 1'b0;
      epc_write = 1'b0;
    end
  end

  assign cause   = cause_q;
  assign state_o = state_q;

endmodule

// File: doc/mc_ctrl_gen.md
# mc_ctrl_gen

Parametrised multicycle MIPS control unit: a Moore-style FSM that sequences fetch, decode, execute, memory and write-back, and drives every datapath enable and mux select. It succeeds the fixed-timing controller with three additions:
- req/ready handshakes to instruction and data memory, allowing variable wait states;
- a bounded wait timeout;
- configurable overflow handling, including a precise trap to an exception vector with EPC/cause capture.

## Interface
- TIMEOUT, 16: max wait cycles on any memory handshake; 0 disables timeout.
- OVF_MODE, 1: 0 = ignore overflow; 1 = write 1 to $30; 2 = trap.
- ILL_TRAP, 1: 1 = unsupported instruction traps; 0 = treated as nop.
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high.
- opcode, funct  in  6 each  IR[31:26], IR[5:0].
- zero, overflow  in  1 each  ALU flags, combinational from registered operands.
- imem_ready, dmem_ready  in  1 each  memory completion strobes.
- imem_req, dmem_req  out  1 each  memory request.
- pc_write, ir_write, reg_write, mem_write, epc_write  out  1 each  write enables.
- alu_src, lb_sign, sb_sign  out  1 each  decode selects.
- reg_dst  out  2  00 rt, 01 rd, 10 $31, 11 $30.
- mem_to_reg  out  3  000 ALU, 001 DM, 010 PC+4, 011 const 1.
- npc_op  out  3  000 PC+4, 001 relative, 010 absolute, 011 rs, 100 exception vector.
- ext_op  out  2  00 zero, 01 sign, 10 lui.
- alu_op  out  3  000 addu, 001 subu, 010 or, 011 slt, 100 signed add, 101 lui.
- cause  out  2  last trap cause: 01 overflow, 10 illegal, 11 bus timeout.
- state_o  out  4  current state, for debug.

## Operation
- **Supported instructions:**
  - R-type (op 0): addu 0x21, subu 0x23, slt 0x2A, jr 0x08.
  - I/J-type: ori 0x0D, lui 0x0F, addi 0x08, addiu 0x09, lw 0x23, lb 0x20, sw 0x2B, sb 0x28, beq 0x04, bne 0x05, j 0x02, jal 0x03.
- **States:** IF=0, ID=1, EXE_LS=2, MEM_ST=3, MEM_LD=4, WB_DM=5, EXE_BR=6, EXE_CAL=7, WB_CAL=8, WB_JAL=9, EXE_JR=10, BRANCH=11, TRAP=12. Encodings 13–15 go to IF.
- **IF:**
  - imem_req=1.
  - On imem_ready: ir_write=1, pc_write=1, npc_op=000, next state ID. Otherwise stay in IF.
- **ID:** next state by instruction class:
  - j → BRANCH; jal → WB_JAL; jr → EXE_JR.
  - Loads/stores → EXE_LS.
  - beq/bne → EXE_BR.
  - Arithmetic/logic → EXE_CAL.
  - Unsupported → TRAP if ILL_TRAP=1, else IF.
- **Memory path:**
  - EXE_LS → MEM_LD for loads, MEM_ST for stores.
  - MEM_ST: dmem_req=1 and mem_write=1 held until dmem_ready, then IF.
  - MEM_LD: dmem_req=1 until dmem_ready, then WB_DM. WB_DM → IF.
- **Arithmetic path:**
  - At the EXE_CAL exit edge, ovf_q <= overflow & (op==addi).
  - With OVF_MODE=2 and ovf_q set, EXE_CAL goes to TRAP (cause 01) and no reg_write occurs. Otherwise EXE_CAL → WB_CAL.
  - WB_CAL: reg_write=1. With OVF_MODE=1 and ovf_q set, force reg_dst=11 and mem_to_reg=011.
- **Jumps and branches:**
  - WB_JAL: reg_write=1, reg_dst=10, mem_to_reg=010, then BRANCH.
  - EXE_JR → BRANCH. EXE_BR → BRANCH.
  - BRANCH: pc_write=1 for j/jal/jr, for beq&zero, and for bne&!zero. Then IF.
- **TRAP:** epc_write=1, pc_write=1, npc_op=100; cause latched. Next state IF.
- **Timeout:**
  - A wait counter clears on entry to IF/MEM_ST/MEM_LD and increments each cycle ready is low.
  - If TIMEOUT≠0 and the counter reaches TIMEOUT with ready still low: drop req, go to TRAP with cause 11. No write enable fires in that cycle.
- **Decode selects:** alu_src, ext_op, alu_op, lb_sign, sb_sign are pure decodes of opcode/funct and are valid from ID onward. All write enables and req lines are decoded from state only, gated by !reset.

## Timing
- **Reset (async):** state=IF, counter=0, ovf_q=0, cause=00. All write enables 0 while reset is high. imem_req=1 from the first cycle after release.
- **Cycle counts with zero-wait memory** (ready high in the first cycle):
  - R/I ALU ops: 4 cycles.
  - lw/lb: 5; sw/sb: 4.
  - beq/bne: 4; j: 3; jal: 4; jr: 4.
  - Trapped addi: 4 (IF, ID, EXE_CAL, TRAP).
- Each wait cycle adds 1 cycle.
- **Simultaneous events:** ready wins over timeout in the same cycle.
- **Reset mid-instruction:** aborts the instruction with no writes and returns to IF.

## Test plan
- **addu with imem_ready low for 2 cycles:** state trace 0,0,0,1,7,8,0; reg_write high only in state 8 with reg_dst=01.
- **beq zero=1 then bne zero=1:** pc_write in BRANCH with npc_op=001 for beq; no pc_write in BRANCH for bne.
- **lw with dmem_ready after 3 cycles:** MEM_LD held 3 cycles; then WB_DM with mem_to_reg=001, reg_dst=00.
- **addi with overflow=1:**
  - OVF_MODE=1: WB_CAL writes reg_dst=11, mem_to_reg=011.
  - OVF_MODE=2: TRAP with cause=01, epc_write=1, npc_op=100, and no reg_write.
- **TIMEOUT=4, dmem_ready never asserted on sw:** after 4 MEM_ST cycles go to TRAP with cause=11; mem_write must not appear in the TRAP cycle.
- **Opcode 0x3F with ILL_TRAP=1:** ID→TRAP, cause=10. **Reset asserted in MEM_ST:** state goes to 0 asynchronously with mem_write=0.
